// File: rtl/rr_arbiter_merge_if.sv
// Handshake bundle for rr_arbiter_merge: N input valid/ready streams and one tagged output stream.
// master = arbiter side, slave = the surrounding producers/consumer.
interface rr_arbiter_merge_if #(
  parameter int unsigned p_nbits   = 32,
  parameter int unsigned p_ninputs = 8
);
  localparam int unsigned p_idxw = $clog2(p_ninputs);

  logic [p_ninputs-1:0]      istream_val;
  logic [p_ninputs-1:0]      istream_rdy;
  logic [p_nbits-1:0]        istream_msg [p_ninputs];
  logic                      ostream_val;
  logic                      ostream_rdy;
  logic [p_nbits+p_idxw-1:0] ostream_msg;

  modport master (
    input  istream_val,
    input  istream_msg,
    output istream_rdy,
    output ostream_val,
    input  ostream_rdy,
    output ostream_msg
  );

  modport slave (
    output istream_val,
    output istream_msg,
    input  istream_rdy,
    input  ostream_val,
    output ostream_rdy,
    input  ostream_msg
  );
endinterface

// File: rtl/rr_arbiter_merge.sv
// Round-robin merge of p_ninputs streams into one registered output tagged with the source index.
// Define RR_ARBITER_MERGE_SKID_EN for a two-entry output so istream_rdy no longer sees ostream_rdy.
module rr_arbiter_merge #(
  parameter int unsigned p_nbits   = 32,
  parameter int unsigned p_ninputs = 8
) (
  input logic                clk,
  input logic                reset,
  rr_arbiter_merge_if.master bus
);
  localparam int unsigned p_idxw  = $clog2(p_ninputs);
  localparam int unsigned p_obits = p_nbits + p_idxw;

  logic [p_idxw-1:0]  r_ptr;
  logic               r_full;
  logic [p_obits-1:0] r_msg;
`ifdef RR_ARBITER_MERGE_SKID_EN
  logic               r_skid_full;
  logic [p_obits-1:0] r_skid_msg;
`endif

  logic               w_found;
  logic [p_idxw-1:0]  w_gidx;
  logic               w_can_accept;
  logic               w_xfer_in;
  logic               w_drain;
  logic [p_obits-1:0] w_new_msg;

  // Cyclic search from r_ptr; p_ninputs is a power of two so the index wraps for free.
  always_comb begin : grant_search
    logic [p_idxw-1:0] cand;
    w_found = 1'b0;
    w_gidx  = '0;
    cand    = '0;
    for (int unsigned k = 0; k < p_ninputs; k++) begin
      cand = r_ptr + p_idxw'(k);
      if (!w_found && bus.istream_val[cand]) begin
        w_found = 1'b1;
        w_gidx  = cand;
      end
    end
  end

  assign w_drain = r_full && bus.ostream_rdy;
`ifdef RR_ARBITER_MERGE_SKID_EN
  assign w_can_accept = !r_skid_full;
`else
  assign w_can_accept = !r_full || w_drain;
`endif
  // Gating with reset keeps every ready low while reset is held.
  assign w_xfer_in = reset && w_found && w_can_accept;
  assign w_new_msg = {w_gidx, bus.istream_msg[w_gidx]};

  always_comb begin
    bus.istream_rdy = '0;
    if (w_xfer_in) bus.istream_rdy[w_gidx] = 1'b1;
  end

  assign bus.ostream_val = r_full;
  assign bus.ostream_msg = r_msg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_full      <= 1'b0;
      r_msg       <= '0;
`ifdef RR_ARBITER_MERGE_SKID_EN
      r_skid_full <= 1'b0;
      r_skid_msg  <= '0;
`endif
    end else begin
      if (w_xfer_in) r_ptr <= w_gidx + p_idxw'(1);
`ifdef RR_ARBITER_MERGE_SKID_EN
      if (!r_full || w_drain) begin
        // Main entry is free this cycle; skid contents go first to keep FIFO order.
        if (r_skid_full) begin
          r_msg       <= r_skid_msg;
          r_full      <= 1'b1;
          r_skid_full <= w_xfer_in;
          if (w_xfer_in) r_skid_msg <= w_new_msg;
        end else if (w_xfer_in) begin
          r_msg  <= w_new_msg;
          r_full <= 1'b1;
        end else begin
          r_full <= 1'b0;
        end
      end else if (w_xfer_in) begin
        r_skid_msg  <= w_new_msg;
        r_skid_full <= 1'b1;
      end
`else
      if (w_xfer_in) begin
        r_msg  <= w_new_msg;
        r_full <= 1'b1;
      end else if (w_drain) begin
        r_full <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_rr_arbiter_merge.sv
// Directed, table-driven bench for rr_arbiter_merge with 4 inputs of 8 bits (10-bit output).
// Inputs change on the falling edge; all checks sample 1 time unit later.
module tb_rr_arbiter_merge;
  localparam int unsigned NB = 8;
  localparam int unsigned NI = 4;

  logic clk;
  logic reset;

  rr_arbiter_merge_if #(.p_nbits(NB), .p_ninputs(NI)) bus ();

  rr_arbiter_merge #(.p_nbits(NB), .p_ninputs(NI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0]  val;
    logic [31:0] msgs;  // {m3, m2, m1, m0}
    logic        ordy;
    logic [3:0]  rdy;
    logic        oval;
    logic [9:0]  omsg;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic [3:0] val, input logic [31:0] msgs, input logic ordy);
    bus.istream_val = val;
    for (int i = 0; i < int'(NI); i++) bus.istream_msg[i] = msgs[8*i +: 8];
    bus.ostream_rdy = ordy;
  endtask

  task automatic expect_all(input string name, input logic [3:0] rdy, input logic oval,
                            input logic [9:0] omsg);
    chk({name, "_rdy"}, 32'(bus.istream_rdy), 32'(rdy));
    chk({name, "_oval"}, 32'(bus.ostream_val), 32'(oval));
    chk({name, "_omsg"}, 32'(bus.ostream_msg), 32'(omsg));
  endtask

  task automatic step(input string name, input logic [3:0] val, input logic [31:0] msgs,
                      input logic ordy, input logic [3:0] rdy, input logic oval,
                      input logic [9:0] omsg);
    @(negedge clk);
    drive(val, msgs, ordy);
    #1;
    expect_all(name, rdy, oval, omsg);
  endtask

  initial begin
    // Round robin over all four, then pointer skip, then idle.
    tbl[0] = '{4'hF, 32'h13121110, 1'b1, 4'b0001, 1'b0, 10'h000};
    tbl[1] = '{4'hF, 32'h13121110, 1'b1, 4'b0010, 1'b1, 10'h010};
    tbl[2] = '{4'hF, 32'h13121110, 1'b1, 4'b0100, 1'b1, 10'h111};
    tbl[3] = '{4'hF, 32'h13121110, 1'b1, 4'b1000, 1'b1, 10'h212};
    tbl[4] = '{4'hF, 32'h13121110, 1'b1, 4'b0001, 1'b1, 10'h313};
    tbl[5] = '{4'h2, 32'h13121110, 1'b1, 4'b0010, 1'b1, 10'h010};
    tbl[6] = '{4'h9, 32'h13121110, 1'b1, 4'b1000, 1'b1, 10'h111};
    tbl[7] = '{4'h9, 32'h13121110, 1'b1, 4'b0001, 1'b1, 10'h313};
    tbl[8] = '{4'h0, 32'h13121110, 1'b1, 4'b0000, 1'b1, 10'h010};
    tbl[9] = '{4'h0, 32'h13121110, 1'b0, 4'b0000, 1'b0, 10'h010};

    reset = 1'b0;
    drive(4'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    expect_all("init", 4'b0000, 1'b0, 10'h000);

    // Single input 2, then hold it in the output register.
    step("single_acc", 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b0, 10'h000);
    step("single_out", 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b1, 10'h2A5);

    // Asynchronous reset while the output is full and inputs are valid.
    #1 reset = 1'b0;
    #1 drive(4'hF, 32'h13121110, 1'b0);
    #1 expect_all("reset_mid", 4'b0000, 1'b0, 10'h000);
    @(negedge clk);
    reset = 1'b1;
    drive(4'h0, 32'h0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].val, tbl[i].msgs, tbl[i].ordy);
      #1;
      expect_all($sformatf("row%0d", i), tbl[i].rdy, tbl[i].oval, tbl[i].omsg);
    end

`ifndef RR_ARBITER_MERGE_SKID_EN
    // Backpressure: fill, stall three cycles, then drain and accept together.
    step("bp_fill", 4'b0100, 32'h00550000, 1'b0, 4'b0100, 1'b0, 10'h010);
    for (int i = 0; i < 3; i++)
      step($sformatf("bp_stall%0d", i), 4'hF, 32'h23222120, 1'b0, 4'b0000, 1'b1, 10'h255);
    step("bp_release", 4'hF, 32'h23222120, 1'b1, 4'b1000, 1'b1, 10'h255);
    step("bp_next", 4'h0, 32'h0, 1'b1, 4'b0000, 1'b1, 10'h323);
    step("bp_empty", 4'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 10'h323);
`else
    // Skid: two accepts under backpressure, then refuse, then drain in order.
    step("skid_acc0", 4'b0110, 32'h00323100, 1'b0, 4'b0010, 1'b0, 10'h010);
    step("skid_acc1", 4'b0110, 32'h00323100, 1'b0, 4'b0100, 1'b1, 10'h131);
    step("skid_full", 4'b0110, 32'h00323100, 1'b0, 4'b0000, 1'b1, 10'h131);
    step("skid_out0", 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b1, 10'h131);
    step("skid_out1", 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b1, 10'h232);
    step("skid_empty", 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 10'h232);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_merge.md
Name: rr_arbiter_merge

Overview:
- Upstream neighbour of the packet router: merges p_ninputs valid/ready streams into one.
- Arbitration is round-robin.
- Prepends the winning input's index as the top clog2(p_ninputs) bits of the outgoing message, giving the router a return/destination tag.
- Output is registered, so one pipeline stage sits between the arbiter and the router.

Parameters:
p_nbits, 32, payload width of each input message
p_ninputs, 8, number of input streams; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
istream_val  input  1 [0:p_ninputs-1]  per-input valid
istream_rdy  output  1 [0:p_ninputs-1]  per-input ready
istream_msg  input  p_nbits [0:p_ninputs-1]  per-input payload
ostream_val  output  1  output valid
ostream_rdy  input  1  output ready (from router ready_out)
ostream_msg  output  p_nbits+clog2(p_ninputs)  {source index, payload}

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed):
  - ostream_val=0, ostream_msg=0, priority pointer ptr=0, output register empty.
  - All istream_rdy=0 while reset is low.
- Transfer rules:
  - Input i transfers when istream_val[i] && istream_rdy[i].
  - Output transfers when ostream_val && ostream_rdy.
- can_accept = !out_full || (ostream_val && ostream_rdy). Full throughput: one message per cycle.
- Grant:
  - Combinational one-hot.
  - Grant the lowest index g, searching cyclically from ptr: ptr, ptr+1, ..., wrapping mod p_ninputs, with istream_val[g]=1.
  - No valid inputs means no grant.
- istream_rdy[g] = grant[g] && can_accept. All non-granted inputs have rdy=0.
  - istream_rdy depends combinationally on istream_val and ostream_rdy. This is permitted, documented, and must not form a loop with the router, which is combinational from ostream_rdy.
- On an input transfer from g:
  - out_reg <= {g[clog2-1:0], istream_msg[g]}; out_full <= 1.
  - ptr <= (g+1) mod p_ninputs.
- No input transfer: ptr holds.
  - If the output transfers, out_full <= 0.
- Latency: 1 cycle from input accept to ostream_val.
- ostream_val = out_full; ostream_msg = out_reg.
  - Stable while ostream_val && !ostream_rdy.
- Simultaneous output drain and input accept: the register is overwritten with the new message and stays full.
- ptr wrap: from p_ninputs-1 back to 0.
- Reset asserted mid-transfer: the pending output message is discarded and ptr returns to 0.
- Fairness: with all inputs continuously valid and ostream_rdy=1, each input is granted exactly once per p_ninputs cycles.

Optional Feature:
- Macro: RR_ARBITER_MERGE_SKID_EN.
- Defined:
  - Adds a second (skid) output entry. can_accept = !skid_full, a pure register output, so istream_rdy has no combinational dependence on ostream_rdy.
  - Accepted messages go to the main entry if it is empty or draining, otherwise to skid.
  - When main drains, skid moves into main. FIFO order is preserved.
  - Reset clears both entries.
- Undefined: single-entry behaviour as above.

Test Plan (p_nbits=8, p_ninputs=4, ostream_msg 10 bits):
1. Reset: assert reset=0 while ostream_val=1 with ostream_msg=0x2A5 -> ostream_val=0 and ostream_msg=0 immediately; after release, input 0 granted first.
2. Single input: istream_val[2]=1, msg=0xA5, ostream_rdy=1 -> istream_rdy[2]=1 that cycle; next cycle ostream_val=1, ostream_msg=0x2A5.
3. Round-robin: all four inputs valid, msgs 0x10/0x11/0x12/0x13, ostream_rdy=1 -> outputs 0x010, 0x111, 0x212, 0x313, 0x010 on consecutive cycles.
4. Pointer skip: grant input 1 (ptr becomes 2), then only inputs 0 and 3 valid -> input 3 granted first (0x3xx), then input 0.
5. Backpressure: output full, ostream_rdy=0 for 3 cycles -> all istream_rdy=0 (skid off), ostream_msg stable; ostream_rdy=1 -> drain plus new accept in the same cycle.
6. Skid (RR_ARBITER_MERGE_SKID_EN): ostream_rdy=0, two inputs valid -> two accepts, then all istream_rdy=0; release -> outputs emerge in accept order on 2 consecutive cycles.
